// File: rtl/udm_max_finder.sv
//==============================================================================
// Module  : udm_max_finder
// Brief   : UDM bus slave that buffers DEPTH words and scans them for the
//           maximum value and its index. Signed compare when
//           UDM_MAX_FINDER_SIGNED_EN is defined, unsigned otherwise.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module udm_max_finder #(
  parameter int         DEPTH      = 16,
  parameter logic [3:0] BUF_REGION = 4'h1,
  parameter logic [3:0] RES_REGION = 4'h2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [31:0] host_addr_i,
  input  logic [3:0]  host_be_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_ack_o,
  output logic        host_resp_o,
  output logic [31:0] host_rdata_o
);

  localparam int c_idx_w = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [31:0]          r_buf [DEPTH];
  logic [DEPTH-1:0]     r_mask;
  logic [31:0]          r_cand_val;
  logic [c_idx_w-1:0]   r_cand_idx;
  logic [c_idx_w-1:0]   r_ptr;
  logic [31:0]          r_max_val;
  logic [c_idx_w-1:0]   r_max_idx;
  logic                 r_done;

  logic                 w_acc;
  logic                 w_rd;
  logic                 w_buf_wr;
  logic [3:0]           w_region;
  logic [c_idx_w-1:0]   w_idx;
  logic                 w_busy;
  logic                 w_greater;
  logic [31:0]          w_next_val;
  logic [c_idx_w-1:0]   w_next_idx;
  logic [DEPTH-1:0]     w_mask_nxt;
  logic [31:0]          w_rdata;

  // The bus is stalled for the whole scan so the buffer cannot change under it.
  assign w_busy     = (r_state == ST_SCAN);
  assign host_ack_o = host_req_i && !w_busy;
  assign w_acc      = host_req_i && host_ack_o;
  assign w_rd       = w_acc && !host_we_i;
  assign w_region   = host_addr_i[31:28];
  assign w_idx      = host_addr_i[c_idx_w+1:2];
  assign w_buf_wr   = w_acc && host_we_i && (w_region == BUF_REGION);

`ifdef UDM_MAX_FINDER_SIGNED_EN
  assign w_greater = $signed(r_buf[r_ptr]) > $signed(r_cand_val);
`else
  assign w_greater = r_buf[r_ptr] > r_cand_val;
`endif

  // Strictly-greater update keeps the lowest index on ties.
  assign w_next_val = w_greater ? r_buf[r_ptr] : r_cand_val;
  assign w_next_idx = w_greater ? r_ptr : r_cand_idx;

  always_comb begin
    w_mask_nxt = r_mask;
    if ((r_state == ST_IDLE) && (&r_mask)) begin
      w_mask_nxt = '0;
    end
    if (w_buf_wr) begin
      w_mask_nxt[w_idx] = 1'b1;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_region == RES_REGION) begin
      case (host_addr_i[27:0])
        28'h0:   w_rdata = r_max_val;
        28'h4:   w_rdata = {{(32-c_idx_w){1'b0}}, r_max_idx};
        28'h8:   w_rdata = {30'b0, w_busy, r_done};
        default: w_rdata = '0;
      endcase
    end else if (w_region == BUF_REGION) begin
      w_rdata = r_buf[w_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_buf_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (host_be_i[b]) begin
          r_buf[w_idx][8*b +: 8] <= host_wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_cand_val   <= '0;
      r_cand_idx   <= '0;
      r_ptr        <= '0;
      r_max_val    <= '0;
      r_max_idx    <= '0;
      r_done       <= 1'b0;
      host_resp_o  <= 1'b0;
      host_rdata_o <= '0;
    end else begin
      host_resp_o <= w_rd;
      if (w_rd) begin
        host_rdata_o <= w_rdata;
      end
      r_mask <= w_mask_nxt;

      case (r_state)
        ST_IDLE: begin
          if (&r_mask) begin
            r_state    <= ST_SCAN;
            r_cand_val <= r_buf[0];
            r_cand_idx <= '0;
            r_ptr      <= c_idx_w'(1);
          end
        end
        ST_SCAN: begin
          r_cand_val <= w_next_val;
          r_cand_idx <= w_next_idx;
          r_ptr      <= r_ptr + c_idx_w'(1);
          if (r_ptr == {c_idx_w{1'b1}}) begin
            r_state   <= ST_DONE;
            r_max_val <= w_next_val;
            r_max_idx <= w_next_idx;
            r_done    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_buf_wr) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_udm_max_finder.sv
//==============================================================================
// Module  : tb_udm_max_finder
// Brief   : Directed scoreboard bench for udm_max_finder (both compare builds).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_udm_max_finder;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        host_req_i = 1'b0;
  logic        host_we_i = 1'b0;
  logic [31:0] host_addr_i = '0;
  logic [3:0]  host_be_i = '0;
  logic [31:0] host_wdata_i = '0;
  logic        host_ack_o;
  logic        host_resp_o;
  logic [31:0] host_rdata_o;

  udm_max_finder dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_be_i    (host_be_i),
    .host_wdata_i (host_wdata_i),
    .host_ack_o   (host_ack_o),
    .host_resp_o  (host_resp_o),
    .host_rdata_o (host_rdata_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef UDM_MAX_FINDER_SIGNED_EN
  localparam logic [31:0] c_a_val  = 32'h55aa55aa;
  localparam logic [31:0] c_a_idx  = 32'h1;
  localparam logic [31:0] c_f_val  = 32'h55aa55aa;
  localparam logic [31:0] c_f_idx  = 32'h1;
  localparam logic [31:0] c_be_val = 32'h00000007;
  localparam logic [31:0] c_be_idx = 32'h0;
`else
  localparam logic [31:0] c_a_val  = 32'hfefe8800;
  localparam logic [31:0] c_a_idx  = 32'ha;
  localparam logic [31:0] c_f_val  = 32'hffffffff;
  localparam logic [31:0] c_f_idx  = 32'h5;
  localparam logic [31:0] c_be_val = 32'h80000009;
  localparam logic [31:0] c_be_idx = 32'h2;
`endif

  logic [31:0] data_a [16] = '{
    32'h112233cc, 32'h55aa55aa, 32'h01010202, 32'h44556677,
    32'h00000003, 32'h00000004, 32'h00000005, 32'h00000006,
    32'h00000007, 32'hdeadbeef, 32'hfefe8800, 32'h23344556,
    32'h05050505, 32'h07070707, 32'h99999999, 32'hbadc0ffe
  };

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q [$];
  logic        acc_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic bus_op(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic [31:0] exp, output int waited);
    @(negedge clk_i);
    host_req_i   = 1'b1;
    host_we_i    = we;
    host_addr_i  = addr;
    host_wdata_i = data;
    host_be_i    = be;
    waited = 0;
    #1;
    while (!host_ack_o && waited < 100) begin
      @(negedge clk_i);
      #1;
      waited++;
    end
    if (!host_ack_o) begin
      check("ack timeout", {31'b0, host_ack_o}, 32'h1);
      host_req_i = 1'b0;
    end else begin
      if (!we) exp_q.push_back(exp);
      @(posedge clk_i);
      #1;
      host_req_i = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    int w;
    bus_op(1'b1, addr, data, be, 32'h0, w);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    int w;
    bus_op(1'b0, addr, 32'h0, 4'h0, exp, w);
  endtask

  task automatic load(input logic [31:0] d [16]);
    for (int i = 0; i < 16; i++) wr(32'h1000_0000 + 32'(i * 4), d[i], 4'hf);
  endtask

  task automatic read_results(input logic [31:0] status, input logic [31:0] val, input logic [31:0] idx);
    rd(32'h2000_0008, status);
    rd(32'h2000_0000, val);
    rd(32'h2000_0004, idx);
  endtask

  // Monitor: accepted reads are sampled between edges, responses checked just after the edge.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      acc_rd = host_req_i && host_ack_o && !host_we_i && rstn_i;
      @(posedge clk_i);
      #1;
      if (acc_rd || host_resp_o) begin
        check("resp timing", {31'b0, host_resp_o}, {31'b0, acc_rd});
        if (host_resp_o) begin
          if (exp_q.size() == 0) check("unexpected resp", 32'h1, 32'h0);
          else check("read data", host_rdata_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] data_f [16];
    logic [31:0] data_t [16];
    int          waited;

    data_f = data_a;
    data_f[5] = 32'hffffffff;
    for (int i = 0; i < 16; i++) data_t[i] = 32'h7;

    // Reset state
    rstn_i = 1'b0;
    idle(3);
    check("reset ack", {31'b0, host_ack_o}, 32'h0);
    check("reset resp", {31'b0, host_resp_o}, 32'h0);
    check("reset rdata", host_rdata_o, 32'h0);
    rstn_i = 1'b1;
    rd(32'h2000_0008, 32'h0);

    // Ignored result-region write, unmapped read
    wr(32'h2000_0000, 32'h12345678, 4'hf);
    rd(32'h2000_0000, 32'h0);
    rd(32'h3000_0000, 32'h0);

    // Main load
    load(data_a);
    idle(17);
    read_results(32'h1, c_a_val, c_a_idx);

    // Write in DONE returns to IDLE with results retained
    wr(32'h1000_0014, 32'hffffffff, 4'hf);
    read_results(32'h0, c_a_val, c_a_idx);
    load(data_f);
    idle(17);
    read_results(32'h1, c_f_val, c_f_idx);

    // Tie rule
    load(data_t);
    idle(17);
    read_results(32'h1, 32'h7, 32'h0);

    // Byte-enable merge and rewrite before the mask is full
    wr(32'h1000_0008, 32'h80000000, 4'b1000);
    wr(32'h1000_0008, 32'h00000009, 4'b0001);
    for (int i = 0; i < 16; i++) if (i != 2) wr(32'h1000_0000 + 32'(i * 4), 32'h7, 4'hf);
    idle(17);
    read_results(32'h1, c_be_val, c_be_idx);

    // Read stalled by the scan
    load(data_a);
    idle(1);
    bus_op(1'b0, 32'h2000_0000, 32'h0, 4'h0, c_a_val, waited);
    check("scan stall cycles", 32'(waited), 32'd15);
    rd(32'h2000_0008, 32'h1);

    // Reset mid-scan
    load(data_f);
    idle(5);
    rstn_i = 1'b0;
    idle(2);
    check("midscan reset resp", {31'b0, host_resp_o}, 32'h0);
    check("midscan reset rdata", host_rdata_o, 32'h0);
    rstn_i = 1'b1;
    idle(20);
    read_results(32'h0, 32'h0, 32'h0);
    load(data_a);
    idle(17);
    read_results(32'h1, c_a_val, c_a_idx);

    idle(5);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
